// File: rtl/mips_imem_loader.sv
// Instruction memory program loader: packs a big-endian byte stream into 32-bit
// words, writes them at consecutive word addresses and holds the core in reset meanwhile.
module mips_imem_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int IMEM_DEPTH = 1024,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic [7:0]            s_byte,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  cpu_hold
);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

   localparam logic [ADDR_WIDTH:0]   DEPTH_W  = IMEM_DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0]   ONE_CNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_q;
   logic                  s_ready_q, imem_we_q, busy_q, done_q, error_q, cpu_hold_q;
   logic [ADDR_WIDTH-1:0] imem_addr_q, word_idx_q;
   logic [DATA_WIDTH-1:0] imem_wdata_q;
   logic [ADDR_WIDTH:0]   cnt_q;
   logic [1:0]            byte_idx_q;
   logic [23:0]           shreg_q;

   logic                  count_ok_d, last_word_d;
   logic [DATA_WIDTH-1:0] word_d;

   assign count_ok_d  = (word_count != '0) && (word_count <= DEPTH_W);
   assign last_word_d = (({1'b0, word_idx_q} + ONE_CNT) == cnt_q);
   // First three bytes sit in shreg_q; the fourth completes the word directly.
   assign word_d      = {shreg_q, s_byte};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         s_ready_q    <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         cpu_hold_q   <= 1'b1;
         cnt_q        <= '0;
         word_idx_q   <= '0;
         byte_idx_q   <= '0;
         shreg_q      <= '0;
      end else begin
         imem_we_q <= 1'b0;
         done_q    <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (count_ok_d) begin
                     cnt_q      <= word_count;
                     word_idx_q <= '0;
                     byte_idx_q <= '0;
                     error_q    <= 1'b0;
                     cpu_hold_q <= 1'b1;
                     s_ready_q  <= 1'b1;
                     busy_q     <= 1'b1;
                     state_q    <= S_RECV;
                  end else begin
                     error_q <= 1'b1;
                  end
               end
            end
            S_RECV: begin
               // s_ready_q is high throughout RECV, so s_valid alone is the handshake
               if (s_valid) begin
                  byte_idx_q <= byte_idx_q + 2'd1;
                  shreg_q    <= {shreg_q[15:0], s_byte};
                  if (byte_idx_q == 2'd3) begin
                     s_ready_q    <= 1'b0;
                     imem_we_q    <= 1'b1;
                     imem_addr_q  <= word_idx_q;
                     imem_wdata_q <= word_d;
                     state_q      <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (last_word_d) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  word_idx_q <= word_idx_q + ONE_ADDR;
                  byte_idx_q <= '0;
                  s_ready_q  <= 1'b1;
                  state_q    <= S_RECV;
               end
            end
            S_DONE: begin
               cpu_hold_q <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign s_ready    = s_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign cpu_hold   = cpu_hold_q;

endmodule
